// File: rtl/traffic_monitor.sv
// Observer for the two-way traffic-light lamp interface: debounces the lamp
// pattern, tracks the phase order and durations, and flags sticky errors.
module traffic_monitor #(
   parameter int unsigned TICK_DIV   = 100,
   parameter int unsigned STABLE_CYC = 2,
   parameter int unsigned T_G1       = 5,
   parameter int unsigned T_Y1       = 3,
   parameter int unsigned T_G2       = 4,
   parameter int unsigned T_Y2       = 3,
   parameter int unsigned TOL        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       r1,
   input  logic       y1,
   input  logic       g1,
   input  logic       r2,
   input  logic       y2,
   input  logic       g2,
   input  logic       chk_en,
   input  logic       clr_err,
   output logic [1:0] phase,
   output logic       phase_valid,
   output logic [3:0] elapsed,
   output logic [3:0] last_dur,
   output logic       seq_err,
   output logic       conflict_err,
   output logic       timing_err,
   output logic       err_any,
   output logic [7:0] led7
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

   state_t          state;
   logic [5:0]      samp, cand, acc_pat;
   logic [2:0]      scnt;
   logic [PW-1:0]   presc;

   logic            accept, tick, legal;
   logic [1:0]      cand_ph;
   logic [3:0]      t_old;
   logic signed [4:0] diff;
   logic [4:0]      mag;
   logic            seq_set, conf_set, tim_set;

   function automatic logic [7:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h98;
         default: return 8'hFF;
      endcase
   endfunction

   assign accept = (scnt == 3'(STABLE_CYC)) && (cand != acc_pat);
   assign tick   = (presc == PW'(TICK_DIV - 1));

   always_comb begin
      legal   = 1'b1;
      cand_ph = 2'd0;
      case (cand)
         6'b001100: cand_ph = 2'd0;
         6'b010100: cand_ph = 2'd1;
         6'b100001: cand_ph = 2'd2;
         6'b100010: cand_ph = 2'd3;
         default:   legal   = 1'b0;
      endcase
   end

   // Duration deviation in 5-bit signed so a saturated 15 never wraps
   always_comb begin
      case (phase)
         2'd0:    t_old = 4'(T_G1);
         2'd1:    t_old = 4'(T_Y1);
         2'd2:    t_old = 4'(T_G2);
         default: t_old = 4'(T_Y2);
      endcase
      diff = signed'({1'b0, elapsed}) - signed'({1'b0, t_old});
      mag  = diff[4] ? 5'(-diff) : 5'(diff);
   end

   assign seq_set  = accept && legal && (state == TRACK) && (cand_ph != phase + 2'd1);
   assign tim_set  = accept && legal && (state == TRACK) && chk_en && (mag > 5'(TOL));
   assign conf_set = accept && !legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         samp         <= '0;
         cand         <= '0;
         scnt         <= '0;
         acc_pat      <= '0;
         presc        <= '0;
         phase        <= '0;
         phase_valid  <= 1'b0;
         elapsed      <= '0;
         last_dur     <= '0;
         seq_err      <= 1'b0;
         conflict_err <= 1'b0;
         timing_err   <= 1'b0;
         err_any      <= 1'b0;
         led7         <= 8'hC0;
      end else begin
         samp <= {r1, y1, g1, r2, y2, g2};
         if (samp != cand) begin
            cand <= samp;
            scnt <= 3'd1;
         end else if (scnt < 3'(STABLE_CYC)) begin
            scnt <= scnt + 3'd1;
         end

         seq_err      <= seq_set  | (seq_err      & ~clr_err);
         conflict_err <= conf_set | (conflict_err & ~clr_err);
         timing_err   <= tim_set  | (timing_err   & ~clr_err);
         err_any      <= seq_err | conflict_err | timing_err;
         led7         <= (state == TRACK) ? seg7(elapsed) : 8'hBF;

         if (accept) begin
            acc_pat <= cand;
            presc   <= '0;
            elapsed <= '0;
            if (state == TRACK) last_dur <= elapsed;
            if (legal) begin
               phase       <= cand_ph;
               state       <= TRACK;
               phase_valid <= 1'b1;
            end else begin
               state       <= FAULT;
               phase_valid <= 1'b0;
            end
         end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && (state == TRACK) && (elapsed != 4'hF))
               elapsed <= elapsed + 4'd1;
         end
      end
   end

endmodule
